// File: rtl/dds_ctrl_pkg.sv
// Shared selectors, field widths and helpers
// for the DDS channel register bank.
package dds_ctrl_pkg;

  localparam logic [3:0] SEL_FC_LO    = 4'd0;
  localparam logic [3:0] SEL_FC_HI    = 4'd1;
  localparam logic [3:0] SEL_FS_LO    = 4'd2;
  localparam logic [3:0] SEL_FS_HI    = 4'd3;
  localparam logic [3:0] SEL_MA       = 4'd4;
  localparam logic [3:0] SEL_FD       = 4'd5;
  localparam logic [3:0] SEL_PD       = 4'd6;
  localparam logic [3:0] SEL_CODE     = 4'd7;
  localparam logic [3:0] SEL_CODE_LEN = 4'd8;
  localparam logic [3:0] SEL_DIV_LO   = 4'd9;
  localparam logic [3:0] SEL_DIV_HI   = 4'd10;

  localparam int DATA_W = 16;
  localparam int MA_W   = 4;
  localparam int FD_W   = 16;
  localparam int PD_W   = 16;
  localparam int LEN_W  = 5;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/code_serializer.sv
// Per-channel sequence-code bit serialiser,
// MSB-first over len bits, one bit per DIV+1 cycles.
module code_serializer
  import dds_ctrl_pkg::*;
#(
  parameter int CODE_W = 16,
  parameter int DIV_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code,
  input  logic [LEN_W-1:0]  len,
  input  logic [DIV_W-1:0]  div,
  input  logic              restart,
  output logic              code_o,
  output logic              frame_o
);

  localparam int IDX_W = clog2(CODE_W);

  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] top_idx;
  logic [DIV_W-1:0] div_cnt;
  logic [LEN_W-1:0] len_m1;

  assign len_m1  = len - LEN_W'(1);
  assign top_idx = len_m1[IDX_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_idx <= IDX_W'(CODE_W - 1);
      code_o  <= 1'b0;
      frame_o <= 1'b0;
    end else begin
      code_o  <= code[bit_idx];
      frame_o <= 1'b0;
      if (restart) begin
        div_cnt <= '0;
        bit_idx <= top_idx;
      end else if (div_cnt == div) begin
        div_cnt <= '0;
        if (bit_idx == '0) begin
          bit_idx <= top_idx;
          frame_o <= 1'b1;
        end else begin
          bit_idx <= bit_idx - IDX_W'(1);
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/dds_ctrl_regs.sv
// Shadow/active DDS parameter bank with
// per-channel atomic commit and code serialiser.
module dds_ctrl_regs
  import dds_ctrl_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int FREQ_W      = 24,
  parameter int CODE_W      = 16,
  parameter int DIV_W       = 32,
  parameter int DEFAULT_DIV = 9765
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [2:0]            wr_ch,
  input  logic [3:0]            wr_sel,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [NCH-1:0]        commit,
  output logic [NCH*FREQ_W-1:0] fc_o,
  output logic [NCH*FREQ_W-1:0] fs_o,
  output logic [NCH*MA_W-1:0]   ma_o,
  output logic [NCH*FD_W-1:0]   fd_o,
  output logic [NCH*PD_W-1:0]   pd_o,
  output logic [NCH-1:0]        code_o,
  output logic [NCH-1:0]        frame_o
);

  function automatic logic [LEN_W-1:0] eff_len(
    input logic [LEN_W-1:0] l
  );
    if (l != '0 && l <= LEN_W'(CODE_W)) return l;
    return LEN_W'(CODE_W);
  endfunction

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    logic [FREQ_W-1:0] fc_sh, fc_nx, fc_ac;
    logic [FREQ_W-1:0] fs_sh, fs_nx, fs_ac;
    logic [MA_W-1:0]   ma_sh, ma_nx, ma_ac;
    logic [FD_W-1:0]   fd_sh, fd_nx, fd_ac;
    logic [PD_W-1:0]   pd_sh, pd_nx, pd_ac;
    logic [CODE_W-1:0] cd_sh, cd_nx, cd_ac;
    logic [LEN_W-1:0]  ln_sh, ln_nx, ln_ac;
    logic [DIV_W-1:0]  dv_sh, dv_nx, dv_ac;
    logic [LEN_W-1:0]  ser_len;
    logic              wr_hit;

    assign wr_hit = wr_en && (wr_ch == 3'(k));

    // nx is the shadow with this cycle's write folded in,
    // so a same-cycle commit captures the new value
    always_comb begin
      fc_nx = fc_sh;
      fs_nx = fs_sh;
      ma_nx = ma_sh;
      fd_nx = fd_sh;
      pd_nx = pd_sh;
      cd_nx = cd_sh;
      ln_nx = ln_sh;
      dv_nx = dv_sh;
      if (wr_hit) begin
        case (wr_sel)
          SEL_FC_LO:    fc_nx[15:0] = wr_data;
          SEL_FC_HI:    fc_nx[FREQ_W-1:16] = wr_data[FREQ_W-17:0];
          SEL_FS_LO:    fs_nx[15:0] = wr_data;
          SEL_FS_HI:    fs_nx[FREQ_W-1:16] = wr_data[FREQ_W-17:0];
          SEL_MA:       ma_nx = wr_data[MA_W-1:0];
          SEL_FD:       fd_nx = wr_data[FD_W-1:0];
          SEL_PD:       pd_nx = wr_data[PD_W-1:0];
          SEL_CODE:     cd_nx = wr_data[CODE_W-1:0];
          SEL_CODE_LEN: ln_nx = wr_data[LEN_W-1:0];
          SEL_DIV_LO:   dv_nx[15:0] = wr_data;
          SEL_DIV_HI:   dv_nx[DIV_W-1:16] = wr_data[DIV_W-17:0];
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        fc_sh <= '0;
        fs_sh <= '0;
        ma_sh <= '0;
        fd_sh <= '0;
        pd_sh <= '0;
        cd_sh <= '0;
        ln_sh <= LEN_W'(CODE_W);
        dv_sh <= DIV_W'(DEFAULT_DIV);
        fc_ac <= '0;
        fs_ac <= '0;
        ma_ac <= '0;
        fd_ac <= '0;
        pd_ac <= '0;
        cd_ac <= '0;
        ln_ac <= LEN_W'(CODE_W);
        dv_ac <= DIV_W'(DEFAULT_DIV);
      end else begin
        fc_sh <= fc_nx;
        fs_sh <= fs_nx;
        ma_sh <= ma_nx;
        fd_sh <= fd_nx;
        pd_sh <= pd_nx;
        cd_sh <= cd_nx;
        ln_sh <= ln_nx;
        dv_sh <= dv_nx;
        if (commit[k]) begin
          fc_ac <= fc_nx;
          fs_ac <= fs_nx;
          ma_ac <= ma_nx;
          fd_ac <= fd_nx;
          pd_ac <= pd_nx;
          cd_ac <= cd_nx;
          ln_ac <= ln_nx;
          dv_ac <= dv_nx;
        end
      end
    end

    // restart must load the length being committed
    assign ser_len = commit[k] ? eff_len(ln_nx)
                               : eff_len(ln_ac);

    code_serializer #(
      .CODE_W (CODE_W),
      .DIV_W  (DIV_W)
    ) u_ser (
      .clk     (clk),
      .rst_n   (rst_n),
      .code    (cd_ac),
      .len     (ser_len),
      .div     (dv_ac),
      .restart (commit[k]),
      .code_o  (code_o[k]),
      .frame_o (frame_o[k])
    );

    assign fc_o[k*FREQ_W +: FREQ_W] = fc_ac;
    assign fs_o[k*FREQ_W +: FREQ_W] = fs_ac;
    assign ma_o[k*MA_W +: MA_W]     = ma_ac;
    assign fd_o[k*FD_W +: FD_W]     = fd_ac;
    assign pd_o[k*PD_W +: PD_W]     = pd_ac;
  end

endmodule

// File: tb/tb_dds_ctrl_regs.sv
// Directed bench for dds_ctrl_regs
// with hand-computed expectations.
module tb_dds_ctrl_regs;

  localparam int NCH    = 2;
  localparam int FREQ_W = 24;
  localparam int CODE_W = 16;
  localparam int DIV_W  = 32;
  localparam int DDIV   = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  wr_en;
  logic [2:0]            wr_ch;
  logic [3:0]            wr_sel;
  logic [15:0]           wr_data;
  logic [NCH-1:0]        commit;
  logic [NCH*FREQ_W-1:0] fc_o;
  logic [NCH*FREQ_W-1:0] fs_o;
  logic [NCH*4-1:0]      ma_o;
  logic [NCH*16-1:0]     fd_o;
  logic [NCH*16-1:0]     pd_o;
  logic [NCH-1:0]        code_o;
  logic [NCH-1:0]        frame_o;

  int errors = 0;
  int checks = 0;

  dds_ctrl_regs #(
    .NCH         (NCH),
    .FREQ_W      (FREQ_W),
    .CODE_W      (CODE_W),
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (DDIV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_ch   (wr_ch),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .commit  (commit),
    .fc_o    (fc_o),
    .fs_o    (fs_o),
    .ma_o    (ma_o),
    .fd_o    (fd_o),
    .pd_o    (pd_o),
    .code_o  (code_o),
    .frame_o (frame_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // entered and left at a negedge
  task automatic wr(input int ch, input int sel, input int data);
    wr_ch   = 3'(ch);
    wr_sel  = 4'(sel);
    wr_data = 16'(data);
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic cmt(input logic [NCH-1:0] m);
    commit = m;
    @(negedge clk);
    commit = '0;
  endtask

  task automatic capture(input int ch, input int n,
                         output logic [31:0] cv,
                         output logic [31:0] fv);
    cv = '0;
    fv = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cv = {cv[30:0], code_o[ch]};
      fv[i] = frame_o[ch];
    end
  endtask

  logic [31:0] cv, fv;
  int          first;
  logic        any_code;
  logic        seen;

  initial begin
    rst_n = 1'b1;
    wr_en = 1'b0;
    wr_ch = '0;
    wr_sel = '0;
    wr_data = '0;
    commit = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_fc", 32'(fc_o[23:0]), 32'h0);
    chk("rst_code", 32'(code_o), 32'h0);
    chk("rst_frame", 32'(frame_o), 32'h0);
    rst_n = 1'b1;

    // first frame after CODE_W*(DDIV+1) = 80 cycles
    first = -1;
    any_code = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      any_code = any_code | (|code_o);
      if (frame_o[0] && first < 0) first = i;
      if (first >= 0) break;
    end
    chk("first_frame", 32'(first), 32'd80);
    chk("idle_code", 32'(any_code), 32'h0);

    // shadow writes invisible until commit
    wr(0, 0, 16'h5678);
    wr(0, 1, 16'h0012);
    chk("fc0_precommit", 32'(fc_o[23:0]), 32'h0);
    cmt(2'b01);
    chk("fc0_commit", 32'(fc_o[23:0]), 32'h125678);
    chk("fc1_untouched", 32'(fc_o[47:24]), 32'h0);

    // ch1 code 0xA5F0, len 16, one bit per cycle
    wr(1, 7, 16'hA5F0);
    wr(1, 8, 16);
    wr(1, 9, 0);
    wr(1, 10, 0);
    cmt(2'b10);
    capture(1, 32, cv, fv);
    chk("len16_code", cv, 32'hA5F0A5F0);
    chk("len16_frame", fv, 32'h80008000);

    wr(1, 8, 0);
    cmt(2'b10);
    capture(1, 32, cv, fv);
    chk("len0_code", cv, 32'hA5F0A5F0);
    chk("len0_frame", fv, 32'h80008000);

    wr(1, 8, 20);
    cmt(2'b10);
    capture(1, 32, cv, fv);
    chk("len20_code", cv, 32'hA5F0A5F0);
    chk("len20_frame", fv, 32'h80008000);

    // len 3, code 101, each bit held 2 cycles
    wr(1, 7, 16'h0005);
    wr(1, 8, 3);
    wr(1, 9, 1);
    cmt(2'b10);
    capture(1, 12, cv, fv);
    chk("len3_code", cv, 32'h00000CF3);
    chk("len3_frame", fv, 32'h00000820);

    // unused selector and out-of-range channel
    wr(0, 12, 16'hFFFF);
    wr(7, 0, 16'hFFFF);
    wr(7, 4, 16'hFFFF);
    cmt(2'b11);
    chk("bad_fc0", 32'(fc_o[23:0]), 32'h125678);
    chk("bad_fs0", 32'(fs_o[23:0]), 32'h0);
    chk("bad_ma", 32'(ma_o), 32'h0);
    chk("bad_fd", 32'(fd_o), 32'h0);
    chk("bad_pd", 32'(pd_o), 32'h0);
    chk("bad_fc1", 32'(fc_o[47:24]), 32'h0);

    // write + commit in the same cycle
    wr_ch   = 3'd0;
    wr_sel  = 4'd4;
    wr_data = 16'h0009;
    wr_en   = 1'b1;
    commit  = 2'b01;
    @(negedge clk);
    wr_en   = 1'b0;
    commit  = '0;
    chk("ma0_same_cycle", 32'(ma_o[3:0]), 32'h9);
    chk("ma1_untouched", 32'(ma_o[7:4]), 32'h0);

    // async reset mid-frame while code_o[1] is high
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (code_o[1]) begin
        seen = 1'b1;
        break;
      end
    end
    chk("code1_high", 32'(seen), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_ma", 32'(ma_o), 32'h0);
    chk("arst_code", 32'(code_o), 32'h0);
    chk("arst_fc", 32'(fc_o), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cmt(2'b11);
    chk("arst_shadow_fc", 32'(fc_o[23:0]), 32'h0);
    chk("arst_shadow_ma", 32'(ma_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
